// File: rtl/step_controller.sv
// Debug/step consumer: synchronises and debounces the debug switch and step button,
// gates the core with cpu_en and snapshots an observation word after every step.
module step_controller #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int STEP_CYCLES     = 1,
   parameter int CNT_W           = 16
) (
   input  logic             clk_c,
   input  logic             reset,
   input  logic             debug,
   input  logic             step_btn,
   input  logic [31:0]      snap_in,
   output logic             cpu_en,
   output logic             halted,
   output logic             step_done,
   output logic [CNT_W-1:0] step_count,
   output logic [31:0]      snap_out
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int ST_W = $clog2(STEP_CYCLES + 1);

   typedef enum logic [2:0] {
      RUN,
      HALT,
      STEP,
      SNAP,
      WAIT_REL
   } state_t;

   logic             debug_meta_q, debug_s_q;
   logic             btn_meta_q, btn_s_q;
   logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
   logic             btn_db_q, btn_db_d;
   logic             step_req_q, step_req_d;
   state_t           state_q, state_d;
   logic [ST_W-1:0]  step_cnt_q, step_cnt_d;
   logic             cpu_en_q, cpu_en_d;
   logic             halted_q, halted_d;
   logic             step_done_q, step_done_d;
   logic [CNT_W-1:0] step_count_q, step_count_d;
   logic [31:0]      snap_q, snap_d;

   always_comb begin
      db_cnt_d     = '0;
      btn_db_d     = btn_db_q;
      step_req_d   = 1'b0;
      state_d      = state_q;
      step_cnt_d   = step_cnt_q;
      step_count_d = step_count_q;
      snap_d       = snap_q;

      // The debounced level only moves after btn_s has disagreed with it for a full window.
      if (btn_s_q != btn_db_q) begin
         if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            btn_db_d   = btn_s_q;
            step_req_d = btn_s_q;
         end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
         end
      end

      case (state_q)
         RUN: begin
            if (debug_s_q) state_d = HALT;
         end
         HALT: begin
            if (!debug_s_q) begin
               state_d = RUN;
            end else if (step_req_q) begin
               state_d    = STEP;
               step_cnt_d = ST_W'(STEP_CYCLES - 1);
            end
         end
         STEP: begin
            // Capture on the way into SNAP so snap_out and step_count change with step_done.
            if (step_cnt_q == '0) begin
               state_d      = SNAP;
               snap_d       = snap_in;
               step_count_d = step_count_q + CNT_W'(1);
            end else begin
               step_cnt_d = step_cnt_q - ST_W'(1);
            end
         end
         SNAP: begin
            state_d = WAIT_REL;
         end
         WAIT_REL: begin
            if (!btn_db_q) state_d = debug_s_q ? HALT : RUN;
         end
         default: begin
            state_d = RUN;
         end
      endcase

      cpu_en_d    = (state_d == RUN) || (state_d == STEP);
      halted_d    = (state_d == HALT) || (state_d == SNAP) || (state_d == WAIT_REL);
      step_done_d = (state_d == SNAP);
   end

   always_ff @(posedge clk_c) begin
      if (reset) begin
         debug_meta_q <= 1'b0;
         debug_s_q    <= 1'b0;
         btn_meta_q   <= 1'b0;
         btn_s_q      <= 1'b0;
         db_cnt_q     <= '0;
         btn_db_q     <= 1'b0;
         step_req_q   <= 1'b0;
         state_q      <= RUN;
         step_cnt_q   <= '0;
         cpu_en_q     <= 1'b0;
         halted_q     <= 1'b0;
         step_done_q  <= 1'b0;
         step_count_q <= '0;
         snap_q       <= '0;
      end else begin
         debug_meta_q <= debug;
         debug_s_q    <= debug_meta_q;
         btn_meta_q   <= step_btn;
         btn_s_q      <= btn_meta_q;
         db_cnt_q     <= db_cnt_d;
         btn_db_q     <= btn_db_d;
         step_req_q   <= step_req_d;
         state_q      <= state_d;
         step_cnt_q   <= step_cnt_d;
         cpu_en_q     <= cpu_en_d;
         halted_q     <= halted_d;
         step_done_q  <= step_done_d;
         step_count_q <= step_count_d;
         snap_q       <= snap_d;
      end
   end

   assign cpu_en     = cpu_en_q;
   assign halted     = halted_q;
   assign step_done  = step_done_q;
   assign step_count = step_count_q;
   assign snap_out   = snap_q;

endmodule

// File: tb/tb_step_controller.sv
// Bench for step_controller: two instances (1-cycle and 3-cycle steps) share the board
// inputs; a press-level model predicts latency, step length, count and snapshot.
module tb_step_controller;

   localparam int D     = 4;
   localparam int CNT_W = 4;

   logic             clk_c = 1'b0;
   logic             reset;
   logic             debug;
   logic             step_btn;
   logic [31:0]      snap_in;

   logic             cpu_en_a, halted_a, step_done_a;
   logic [CNT_W-1:0] step_count_a;
   logic [31:0]      snap_out_a;
   logic             cpu_en_b, halted_b, step_done_b;
   logic [CNT_W-1:0] step_count_b;
   logic [31:0]      snap_out_b;

   int vectors     = 0;
   int miscompares = 0;
   int cyc, firstEnA, enCntA, enCntB, doneCntA, doneCntB, doneAtA, doneAtB;
   int modelCount;
   logic [31:0] modelSnap;

   step_controller #(.DEBOUNCE_CYCLES(D), .STEP_CYCLES(1), .CNT_W(CNT_W)) dutA (
      .clk_c(clk_c), .reset(reset), .debug(debug), .step_btn(step_btn), .snap_in(snap_in),
      .cpu_en(cpu_en_a), .halted(halted_a), .step_done(step_done_a),
      .step_count(step_count_a), .snap_out(snap_out_a)
   );

   step_controller #(.DEBOUNCE_CYCLES(D), .STEP_CYCLES(3), .CNT_W(CNT_W)) dutB (
      .clk_c(clk_c), .reset(reset), .debug(debug), .step_btn(step_btn), .snap_in(snap_in),
      .cpu_en(cpu_en_b), .halted(halted_b), .step_done(step_done_b),
      .step_count(step_count_b), .snap_out(snap_out_b)
   );

   always #5 clk_c = ~clk_c;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic dbg, input logic btn);
      debug    = dbg;
      step_btn = btn;
   endtask

   task automatic clearMon();
      cyc = 0; firstEnA = -1; enCntA = 0; enCntB = 0;
      doneCntA = 0; doneCntB = 0; doneAtA = -1; doneAtB = -1;
   endtask

   // Inputs change and outputs are sampled on the falling edge, away from the active edge.
   task automatic tick();
      @(negedge clk_c);
      cyc++;
      if (cpu_en_a) begin
         enCntA++;
         if (firstEnA < 0) firstEnA = cyc;
      end
      if (cpu_en_b) enCntB++;
      if (step_done_a) begin doneCntA++; doneAtA = cyc; end
      if (step_done_b) begin doneCntB++; doneAtB = cyc; end
   endtask

   task automatic pressStep(input int nBounce, input bit fixedBounce, input int hold,
                            input logic [31:0] word, input bit expectStep, input string tag);
      int base;
      snap_in = word;
      clearMon();
      for (int b = 0; b < nBounce; b++) begin
         applyStimulus(debug, 1'b1);
         repeat (fixedBounce ? 1 : $urandom_range(1, D - 1)) tick();
         applyStimulus(debug, 1'b0);
         repeat (fixedBounce ? 1 : $urandom_range(1, D - 1)) tick();
      end
      applyStimulus(debug, 1'b1);
      base = cyc;
      repeat (hold) tick();
      applyStimulus(debug, 1'b0);
      repeat (D + 8) tick();
      if (expectStep) begin
         modelCount = (modelCount + 1) % (1 << CNT_W);
         modelSnap  = word;
         checkOutput({tag, " press latency"}, firstEnA - base, 3 + D);
         checkOutput({tag, " en cycles A"}, enCntA, 1);
         checkOutput({tag, " en cycles B"}, enCntB, 3);
         checkOutput({tag, " done pulses A"}, doneCntA, 1);
         checkOutput({tag, " done pulses B"}, doneCntB, 1);
         checkOutput({tag, " done time A"}, doneAtA - base, 3 + D + 1);
         checkOutput({tag, " done time B"}, doneAtB - base, 3 + D + 3);
      end else begin
         checkOutput({tag, " en always A"}, enCntA, cyc);
         checkOutput({tag, " no done A"}, doneCntA, 0);
         checkOutput({tag, " no done B"}, doneCntB, 0);
      end
      checkOutput({tag, " count A"}, 32'(step_count_a), modelCount);
      checkOutput({tag, " count B"}, 32'(step_count_b), modelCount);
      checkOutput({tag, " snap A"}, snap_out_a, modelSnap);
      checkOutput({tag, " snap B"}, snap_out_b, modelSnap);
      checkOutput({tag, " halted after"}, 32'(halted_a), 32'(debug));
      checkOutput({tag, " cpu_en after"}, 32'(cpu_en_a), 32'(!debug));
   endtask

   initial begin
      int edgeAt;
      applyStimulus(1'b0, 1'b0);
      snap_in    = '0;
      reset      = 1'b1;
      modelCount = 0;
      modelSnap  = '0;
      clearMon();

      repeat (3) begin
         tick();
         checkOutput("reset cpu_en", 32'(cpu_en_a), 0);
         checkOutput("reset halted", 32'(halted_a), 0);
      end
      reset = 1'b0;
      tick();
      checkOutput("post-reset cpu_en", 32'(cpu_en_a), 1);
      checkOutput("post-reset count", 32'(step_count_a), 0);
      checkOutput("post-reset snap", snap_out_a, 0);
      checkOutput("post-reset done", 32'(step_done_a), 0);
      clearMon();
      repeat (5) tick();
      checkOutput("run cpu_en held", enCntA, 5);

      applyStimulus(1'b1, 1'b0);
      edgeAt = -1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (!cpu_en_a && edgeAt < 0) edgeAt = i;
      end
      checkOutput("debug on latency", edgeAt, 3);
      checkOutput("debug on halted", 32'(halted_a), 1);
      applyStimulus(1'b0, 1'b0);
      edgeAt = -1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (cpu_en_a && edgeAt < 0) edgeAt = i;
      end
      checkOutput("debug off latency", edgeAt, 3);
      checkOutput("debug off halted", 32'(halted_a), 0);

      applyStimulus(1'b1, 1'b0);
      repeat (6) tick();
      pressStep(0, 1'b1, 20, 32'hDEADBEEF, 1'b1, "clean");
      pressStep(2, 1'b1, 16, 32'h12345678, 1'b1, "bounce");
      for (int i = 0; i < 4; i++)
         pressStep($urandom_range(0, 3), 1'b0, $urandom_range(12, 20), $urandom, 1'b1, "random");

      applyStimulus(1'b0, 1'b0);
      repeat (6) tick();
      pressStep(0, 1'b1, 15, $urandom, 1'b0, "run press");

      applyStimulus(1'b1, 1'b0);
      repeat (6) tick();
      clearMon();
      applyStimulus(1'b1, 1'b1);
      repeat (3 + D) tick();
      checkOutput("mid step cpu_en B", 32'(cpu_en_b), 1);
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0);
      tick();
      checkOutput("mid-step reset cpu_en", 32'(cpu_en_b), 0);
      checkOutput("mid-step reset halted", 32'(halted_b), 0);
      checkOutput("mid-step reset count", 32'(step_count_b), 0);
      checkOutput("mid-step reset snap", snap_out_b, 0);
      checkOutput("mid-step reset done", 32'(step_done_b), 0);
      repeat (2) tick();
      reset = 1'b0;
      tick();
      checkOutput("after reset cpu_en B", 32'(cpu_en_b), 1);
      modelCount = 0;
      modelSnap  = '0;

      applyStimulus(1'b1, 1'b0);
      repeat (6) tick();
      for (int i = 0; i < 17; i++)
         pressStep($urandom_range(0, 2), 1'b0, $urandom_range(12, 20), $urandom, 1'b1, "wrap");
      checkOutput("wrap count A", 32'(step_count_a), 1);
      checkOutput("wrap count B", 32'(step_count_b), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
